// File: rtl/multi_clk_gen_if.sv
// Configuration and waveform bundle for multi_clk_gen.
// master: the controller writing configuration and enables; slave: the generator.
interface multi_clk_gen_if #(
   parameter int NCH = 4,
   parameter int CW  = 16,
   parameter int JW  = 4
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic            cfg_valid;
   logic [CHW-1:0]  cfg_ch;
   logic [CW-1:0]   cfg_period;
   logic [CW-1:0]   cfg_high;
   logic [JW-1:0]   cfg_jitter;
   logic [NCH-1:0]  en;
   logic [NCH-1:0]  clk_out;
   logic [NCH-1:0]  rise;
   logic            cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_jitter, en,
      input  clk_out, rise, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_jitter, en,
      output clk_out, rise, cfg_err
   );
endinterface

// File: rtl/multi_clk_gen.sv
// multi_clk_gen: NCH independent divided waveforms from one system clock, each
// with programmable period, high time and LFSR-driven period jitter.
module multi_clk_gen #(
   parameter int          NCH  = 4,
   parameter int          CW   = 16,
   parameter int          JW   = 4,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic           clk,
   input  logic           rst,
   multi_clk_gen_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   logic [15:0]    lfsr;
   logic           err_q;
   logic           cfg_legal;
   logic [NCH-1:0] wr_sel;
   logic [NCH-1:0] start;
   logic [NCH-1:0] pend;
   logic [NCH-1:0] clk_q;
   logic [NCH-1:0] rise_q;

   state_t         st    [NCH];
   logic [CW-1:0]  cnt   [NCH];
   logic [CW-1:0]  pe    [NCH];
   logic [CW-1:0]  p_act [NCH];
   logic [CW-1:0]  h_act [NCH];
   logic [JW-1:0]  j_act [NCH];
   logic [CW-1:0]  p_pnd [NCH];
   logic [CW-1:0]  h_pnd [NCH];
   logic [JW-1:0]  j_pnd [NCH];
   logic [CW-1:0]  p_use [NCH];
   logic [CW-1:0]  h_use [NCH];
   logic [JW-1:0]  j_use [NCH];
   logic [CW-1:0]  pe_new[NCH];

   // Effective period: P plus LFSR offset saturated to +/-J, kept within [H+1, 2^CW-1].
   function automatic logic [CW-1:0] calc_pe(input logic [CW-1:0] p, input logic [CW-1:0] h,
                                             input logic [JW-1:0] j, input logic [JW:0] r);
      logic signed [CW+1:0] d, jj, sum, lo, hi;
      d   = signed'({{(CW+1-JW){r[JW]}}, r});
      jj  = signed'({{(CW+2-JW){1'b0}}, j});
      if (d > jj)
         d = jj;
      else if (d < -jj)
         d = -jj;
      sum = signed'({2'b00, p}) + d;
      lo  = signed'({2'b00, h}) + signed'({{(CW+1){1'b0}}, 1'b1});
      hi  = signed'({2'b00, {CW{1'b1}}});
      if (sum < lo)
         sum = lo;
      else if (sum > hi)
         sum = hi;
      return sum[CW-1:0];
   endfunction

   // Write validation, per-channel write decode and period-start selection.
   always_comb begin
      cfg_legal = (bus.cfg_period >= CW'(2)) && (bus.cfg_high != '0) &&
                  (bus.cfg_high < bus.cfg_period) && (int'(bus.cfg_ch) < NCH);
      wr_sel = '0;
      start  = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         wr_sel[k] = bus.cfg_valid && cfg_legal && (int'(bus.cfg_ch) == int'(k));
         // An IDLE channel takes a same-edge write immediately; otherwise pending wins over active.
         if (st[k] == IDLE && wr_sel[k]) begin
            p_use[k] = bus.cfg_period;
            h_use[k] = bus.cfg_high;
            j_use[k] = bus.cfg_jitter;
         end else if (pend[k]) begin
            p_use[k] = p_pnd[k];
            h_use[k] = h_pnd[k];
            j_use[k] = j_pnd[k];
         end else begin
            p_use[k] = p_act[k];
            h_use[k] = h_act[k];
            j_use[k] = j_act[k];
         end
         pe_new[k] = calc_pe(p_use[k], h_use[k], j_use[k], lfsr[JW:0]);
         if (st[k] == IDLE)
            start[k] = bus.en[k];
         else
            start[k] = bus.en[k] && (cnt[k] == pe[k] - 1'b1);
      end
   end

   // Shared Galois LFSR, free-running every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr <= SEED;
      else if (lfsr[0])
         lfsr <= {1'b0, lfsr[15:1]} ^ 16'hB400;
      else
         lfsr <= {1'b0, lfsr[15:1]};
   end

   // Rejected writes pulse cfg_err one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_q <= 1'b0;
      else
         err_q <= bus.cfg_valid && !cfg_legal;
   end

   // Per-channel configuration registers, counter and registered waveform.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend   <= '0;
         clk_q  <= '0;
         rise_q <= '0;
         for (int unsigned k = 0; k < NCH; k++) begin
            st[k]    <= IDLE;
            cnt[k]   <= '0;
            pe[k]    <= CW'(2);
            p_act[k] <= CW'(2);
            h_act[k] <= CW'(1);
            j_act[k] <= '0;
            p_pnd[k] <= CW'(2);
            h_pnd[k] <= CW'(1);
            j_pnd[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < NCH; k++) begin
            if (wr_sel[k]) begin
               p_pnd[k] <= bus.cfg_period;
               h_pnd[k] <= bus.cfg_high;
               j_pnd[k] <= bus.cfg_jitter;
            end
            if (start[k]) begin
               p_act[k] <= p_use[k];
               h_act[k] <= h_use[k];
               j_act[k] <= j_use[k];
               // A RUN write landing on the start edge is deferred to the following start.
               pend[k]  <= (st[k] == RUN) && wr_sel[k];
            end else if (wr_sel[k]) begin
               if (st[k] == IDLE) begin
                  p_act[k] <= bus.cfg_period;
                  h_act[k] <= bus.cfg_high;
                  j_act[k] <= bus.cfg_jitter;
                  pend[k]  <= 1'b0;
               end else begin
                  pend[k]  <= 1'b1;
               end
            end

            if (start[k]) begin
               st[k]     <= RUN;
               cnt[k]    <= '0;
               pe[k]     <= pe_new[k];
               clk_q[k]  <= 1'b1;
               rise_q[k] <= 1'b1;
            end else if (st[k] == RUN && cnt[k] != pe[k] - 1'b1) begin
               cnt[k]    <= cnt[k] + 1'b1;
               clk_q[k]  <= (cnt[k] + 1'b1) < h_act[k];
               rise_q[k] <= 1'b0;
            end else begin
               st[k]     <= IDLE;
               cnt[k]    <= '0;
               clk_q[k]  <= 1'b0;
               rise_q[k] <= 1'b0;
            end
         end
      end
   end

   assign bus.clk_out = clk_q;
   assign bus.rise    = rise_q;
   assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_multi_clk_gen.sv
// Directed bench for multi_clk_gen: waveform shape, deferred writes, rejected
// writes, jitter bounds, enable handling and asynchronous reset.
module tb_multi_clk_gen;
   localparam int NCH = 4;
   localparam int CW  = 16;
   localparam int JW  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multi_clk_gen_if #(.NCH(NCH), .CW(CW), .JW(JW)) bus ();
   multi_clk_gen_if #(.NCH(3),   .CW(CW), .JW(JW)) bus3 ();

   multi_clk_gen #(.NCH(NCH), .CW(CW), .JW(JW), .SEED(16'hACE1)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   multi_clk_gen #(.NCH(3), .CW(CW), .JW(JW), .SEED(16'hACE1)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3)
   );

   int checks = 0;
   int errors = 0;
   int seq [2][16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int ch, input int p, input int h, input int j);
      bus.cfg_ch     = 2'(ch);
      bus.cfg_period = 16'(p);
      bus.cfg_high   = 16'(h);
      bus.cfg_jitter = 4'(j);
      bus.cfg_valid  = 1'b1;
      tick();
      bus.cfg_valid  = 1'b0;
   endtask

   task automatic wait_rise(input int ch);
      int n = 0;
      while (!bus.rise[ch] && n < 200) begin
         tick();
         n++;
      end
      if (!bus.rise[ch])
         check("rise_wait", 32'(bus.rise[ch]), 32'd1);
   endtask

   // Rise-to-rise period and high count; ends on the next rise sample.
   task automatic measure(input int ch, output int hi, output int per);
      hi  = 0;
      per = 0;
      wait_rise(ch);
      do begin
         if (bus.clk_out[ch]) hi++;
         per++;
         tick();
      end while (!bus.rise[ch] && per < 200);
   endtask

   task automatic run_seq(input int idx);
      int hi, per;
      bus.en = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      cfg_write(2, 20, 5, 3);
      bus.en = 4'b0100;
      for (int i = 0; i < 16; i++) begin
         measure(2, hi, per);
         seq[idx][i] = per;
      end
   endtask

   initial begin
      logic [19:0] gc, gr;
      logic [13:0] g14, r14;
      logic [23:0] g24;
      logic        ge;
      int hi, per, pmin, pmax, hbad, diffs, varied;

      rst = 1'b1;
      bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_period = '0;
      bus.cfg_high = '0; bus.cfg_jitter = '0; bus.en = '0;
      bus3.cfg_valid = 1'b0; bus3.cfg_ch = '0; bus3.cfg_period = '0;
      bus3.cfg_high = '0; bus3.cfg_jitter = '0; bus3.en = '0;
      repeat (3) tick();
      check("rst_clk_out", 32'(bus.clk_out), 32'h0);
      check("rst_rise",    32'(bus.rise),    32'h0);
      check("rst_cfg_err", 32'(bus.cfg_err), 32'h0);
      rst = 1'b0;
      tick();

      // ch0 P=10 H=3: three high, seven low, rise every 10
      cfg_write(0, 10, 3, 0);
      check("legal_no_err", 32'(bus.cfg_err), 32'h0);
      bus.en[0] = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         gc[i] = bus.clk_out[0];
         gr[i] = bus.rise[0];
         tick();
      end
      check("ch0_wave", 32'(gc), 32'(20'b0000000_111_0000000_111));
      check("ch0_rise", 32'(gr), 32'(20'b000000000_1_000000000_1));

      // ch1 P=5 H=2, rewritten to P=8 H=4 at cnt=1
      cfg_write(1, 5, 2, 0);
      bus.en[1] = 1'b1;
      tick();
      bus.cfg_ch = 2'd1; bus.cfg_period = 16'd8; bus.cfg_high = 16'd4; bus.cfg_jitter = '0;
      ge = 1'b0;
      for (int i = 0; i < 14; i++) begin
         g14[i] = bus.clk_out[1];
         ge = ge | bus.cfg_err;
         bus.cfg_valid = (i == 1);
         tick();
      end
      bus.cfg_valid = 1'b0;
      check("ch1_deferred", 32'(g14), 32'(14'b1_0000_1111_00011));
      check("ch1_no_err", 32'(ge), 32'h0);

      // Rejected writes: P=1, H=P, H=0
      cfg_write(1, 1, 1, 0);
      check("err_p1", 32'(bus.cfg_err), 32'h1);
      tick();
      check("err_p1_clear", 32'(bus.cfg_err), 32'h0);
      cfg_write(1, 6, 6, 0);
      check("err_h_eq_p", 32'(bus.cfg_err), 32'h1);
      cfg_write(1, 6, 0, 0);
      check("err_h0", 32'(bus.cfg_err), 32'h1);
      tick();
      check("err_h0_clear", 32'(bus.cfg_err), 32'h0);
      measure(1, hi, per);
      check("ch1_after_bad_hi", 32'(hi), 32'd4);
      check("ch1_after_bad_per", 32'(per), 32'd8);

      // NCH=3 instance: channel index 3 is out of range
      bus3.cfg_ch = 2'd3; bus3.cfg_period = 16'd10; bus3.cfg_high = 16'd3; bus3.cfg_valid = 1'b1;
      tick();
      bus3.cfg_valid = 1'b0;
      check("err_ch_range", 32'(bus3.cfg_err), 32'h1);
      bus3.cfg_ch = 2'd2; bus3.cfg_valid = 1'b1;
      tick();
      bus3.cfg_valid = 1'b0;
      check("ch2_in_range", 32'(bus3.cfg_err), 32'h0);

      // ch2 P=20 H=5 J=3 over 1000 periods
      cfg_write(2, 20, 5, 3);
      bus.en[2] = 1'b1;
      pmin = 1000; pmax = 0; hbad = 0;
      for (int i = 0; i < 1000; i++) begin
         measure(2, hi, per);
         if (per < pmin) pmin = per;
         if (per > pmax) pmax = per;
         if (hi != 5) hbad++;
      end
      check("jit_min", 32'(pmin), 32'd17);
      check("jit_max", 32'(pmax), 32'd23);
      check("jit_high_bad", 32'(hbad), 32'd0);

      // ch3 P=6 H=5 J=3: clamped at H+1
      cfg_write(3, 6, 5, 3);
      bus.en[3] = 1'b1;
      pmin = 1000; pmax = 0; hbad = 0;
      for (int i = 0; i < 300; i++) begin
         measure(3, hi, per);
         if (per < pmin) pmin = per;
         if (per > pmax) pmax = per;
         if (hi != 5) hbad++;
      end
      check("clamp_min", 32'(pmin), 32'd6);
      check("clamp_max_le9", 32'(pmax <= 9), 32'd1);
      check("clamp_high_bad", 32'(hbad), 32'd0);

      // ch0: en dropped and re-asserted inside a period, no gap
      wait_rise(0);
      tick();
      bus.en[0] = 1'b0;
      tick();
      bus.en[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         gc[i] = bus.clk_out[0];
         tick();
      end
      check("ch0_no_gap", 32'(gc), 32'(20'b11_0000000_111_0000000_1));

      // ch0: en dropped at cnt=1, period completes then idles low
      wait_rise(0);
      tick();
      bus.en[0] = 1'b0;
      for (int i = 0; i < 14; i++) begin
         g14[i] = bus.clk_out[0];
         r14[i] = bus.rise[0];
         tick();
      end
      check("ch0_stop_wave", 32'(g14), 32'(14'b00000000000011));
      check("ch0_stop_rise", 32'(r14), 32'h0);

      // All channels high together, then asynchronous reset
      bus.en = '0;
      repeat (30) tick();
      check("all_idle", 32'(bus.clk_out), 32'h0);
      for (int c = 0; c < 4; c++) cfg_write(c, 10, 5, 0);
      bus.en = 4'hF;
      tick();
      tick();
      check("all_high", 32'(bus.clk_out), 32'hF);
      rst = 1'b1;
      #1;
      check("async_rst_clk", 32'(bus.clk_out), 32'h0);
      check("async_rst_rise", 32'(bus.rise), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         g24[4*i +: 4] = bus.clk_out;
      end
      check("post_rst_div2", 32'(g24), 32'h0F0F0F);

      // Same seed, same stimulus, same jitter sequence
      run_seq(0);
      run_seq(1);
      diffs = 0; varied = 0;
      for (int i = 0; i < 16; i++) begin
         if (seq[0][i] != seq[1][i]) diffs++;
         if (seq[0][i] != 20) varied = 1;
      end
      check("seed_repeat_diffs", 32'(diffs), 32'd0);
      check("seed_seq_varies", 32'(varied), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multi_clk_gen.md
# multi_clk_gen

Synthesisable, parametrised successor to our behavioural clock-generation benches. It derives NCH independent divided clock waveforms from one system clock. Each channel has a programmable period, high time (duty) and cycle-to-cycle period jitter from a shared LFSR. Outputs drive test stimulus and low-rate enables inside the design; they are not for use as real clock trees.

## Interface
- NCH, 4: number of output channels (1..16).
- CW, 16: period/high-time counter width, in system clock cycles.
- JW, 4: jitter magnitude width; maximum jitter is 2^JW-1 cycles.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

- clk  in  1: system clock; all logic on rising edge.
- rst  in  1: asynchronous, active-high reset.
- cfg_valid  in  1: single-cycle configuration write strobe.
- cfg_ch  in  $clog2(NCH) (min 1): target channel.
- cfg_period  in  CW: nominal period P in clk cycles.
- cfg_high  in  CW: high time H in clk cycles.
- cfg_jitter  in  JW: jitter bound J in clk cycles.
- en  in  NCH: per-channel run enable, level-sensitive.
- clk_out  out  NCH: generated waveforms, registered.
- rise  out  NCH: one-cycle pulse coincident with each clk_out 0->1 transition.
- cfg_err  out  1: one-cycle pulse when a write is rejected.

## Operation
- Per channel: active registers (P, H, J) and pending registers (Pn, Hn, Jn) with a pend flag; counter cnt (CW bits); effective period Pe; state IDLE or RUN.
- Config write is validated as follows:
  - Legal if P >= 2, 1 <= H <= P-1, and cfg_ch < NCH. A legal write loads the pending registers and sets pend.
  - An illegal write leaves all state unchanged and pulses cfg_err in the next cycle.
  - Writes are always accepted; there is no backpressure.
- A write to an IDLE channel copies to the active registers at the same edge.
- A write to a RUN channel is applied at the next period start. Back-to-back writes: the last one before that start wins.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, reset to SEED. It advances every clk cycle regardless of en and is shared by all channels.
- Period start (entering RUN, or cnt == Pe-1 while RUN):
  - Apply pending registers if pend is set, then clear pend.
  - r = signed lfsr[JW:0]; d = r saturated to [-J, +J].
  - Pe = P + d, computed in CW+1 bits. Pe < H+1 clamps to H+1; Pe > 2^CW-1 clamps to 2^CW-1.
  - J = 0 gives Pe = P exactly.
  - cnt = 0.
- RUN: clk_out = (cnt < H); cnt increments each cycle.
- IDLE -> RUN: en=1 sampled at edge t; first high cycle begins at t+1.
- RUN -> IDLE: en=0 is honoured only at the period end (cnt == Pe-1). The current period completes, so the last high pulse is never truncated. At that edge clk_out = 0 and cnt = 0.
- en re-asserted before the period end: the channel stays in RUN with no gap.
- Channels are fully independent except for the shared LFSR.

## Timing
- Reset values: clk_out = 0, rise = 0, cfg_err = 0, all channels IDLE, cnt = 0, pend = 0.
- Active and pending registers reset to P = 2, H = 1, J = 0, giving a 50% duty divide-by-2.
- Reset asserted mid-operation: outputs drop to 0 asynchronously and the channel restarts from IDLE after deassertion.
- Write to IDLE channel at edge t: new values take effect at edge t.
- Write on the same edge as a period start: that start uses the old values; the new values apply at the following start.
- rise asserts in the first high cycle of each period, in the same cycle as clk_out goes high.
- Period of channel k = Pe cycles (edge of rise to next rise). High width = H cycles, exact; jitter affects only low time.

## Test plan
- Reset, write ch0 P=10 H=3 J=0, en[0]=1: clk_out[0] high 3 cycles, low 7; rise every 10 cycles. First high at cycle after en.
- ch1 P=5 H=2 running; write P=8 H=4 mid-period: current period completes at 5 cycles, next period is 8 cycles with 4 high. cfg_err stays 0.
- Illegal writes: P=1; P=6 H=6; H=0; cfg_ch=NCH when NCH is not a power of 2. Each gives a cfg_err pulse one cycle later; running waveform unchanged.
- ch2 P=20 H=5 J=3 over 1000 periods: every period in 17..23 cycles, high always 5. Same SEED gives a reproducible sequence. Also P=6 H=5 J=3 never yields period < 6.
- en[0] dropped at cnt=1 of P=10 H=3: pulse finishes and the low phase completes, then IDLE with clk_out = 0. Re-assert en before period end: no gap.
- rst asserted mid-high on all four channels: clk_out = 0 immediately. After release, registers are at defaults (divide-by-2 when enabled).
